// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
//   Constants and types shared by the fetch sequencer and the PC register.
//   - PC_* : pc_mode encodings understood by the PC register
//   - OPC_JAL : major opcode of JAL
//   - fetch_state_t : fetch sequencer state encoding
// ----------------------------------------------------------------------------
package rv_pkg;

    localparam logic [1:0] PC_STALL  = 2'b00;  // hold PC
    localparam logic [1:0] PC_INCR   = 2'b01;  // pc + 4
    localparam logic [1:0] PC_BRANCH = 2'b11;  // pc + imm
    localparam logic [1:0] PC_JALR   = 2'b10;  // pc = imm

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// fetch_ctrl_if
//   Bundles the instruction-memory bus and the fetch->decode handshake.
//   Signal suffixes are from the fetch sequencer's point of view.
//   master : fetch_ctrl side
//   slave  : memory/decode side (testbench)
//
//   Handshakes:
//   - imem: imem_req_o is held until imem_gnt_i; a granted request is answered
//     by exactly one imem_rvalid_i pulse at least one cycle later.
//   - decode: a word transfers in a cycle where instr_valid_o && instr_ready_i;
//     instr_o/instr_pc_o are stable while instr_valid_o is high and not taken.
// ----------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [31:0]     imem_rdata_i;

    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] instr_pc_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output instr_valid_o, instr_o, instr_pc_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  instr_valid_o, instr_o, instr_pc_o,
        output instr_ready_i
    );
endinterface

// File: rtl/jal_predecode.sv
// ----------------------------------------------------------------------------
// jal_predecode
//   Combinational JAL detector and J-immediate extractor used for static
//   redirect in fetch.
//   i_instr  in  32    instruction word
//   o_is_jal out 1     opcode is JAL
//   o_imm    out XLEN  sign-extended J-immediate (byte offset, bit 0 = 0)
// ----------------------------------------------------------------------------
module jal_predecode
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic            o_is_jal,
    output logic [XLEN-1:0] o_imm
);
    // rd field is not needed to redirect the PC.
    logic w_unused_rd;
    assign w_unused_rd = ^i_instr[11:7];

    assign o_is_jal = (i_instr[6:0] == OPC_JAL);

    // instr[31] is imm[20]; replicate it up to XLEN.
    assign o_imm = {{(XLEN-20){i_instr[31]}}, i_instr[19:12], i_instr[20],
                    i_instr[30:21], 1'b0};
endmodule

// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch sequencer. Keeps one imem transaction in flight, hands
//   the fetched word to decode, then steers the PC register: +4, or +J-imm
//   for JAL. Execute-stage redirects win over everything else.
//   The PC only moves on handoff or redirect, so pc_i is always the address
//   of the word in flight.
//
//   clk, rst_n          clock, asynchronous active-low reset
//   pc_i                current PC
//   pc_mode_o/pc_imm_o  PC register control (combinational)
//   stall_i             hazard stall: no new request
//   redir_valid_i/redir_target_i  execute redirect
//   fetch_cnt_o         delivered instruction count (wraps)
//   state_o             current FSM state (debug)
//   bus                 imem bus + decode handshake (master)
// ----------------------------------------------------------------------------
module fetch_ctrl
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pc_i,
    output logic [1:0]       pc_mode_o,
    output logic [XLEN-1:0]  pc_imm_o,
    input  logic             stall_i,
    input  logic             redir_valid_i,
    input  logic [XLEN-1:0]  redir_target_i,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output fetch_state_t     state_o,
    fetch_ctrl_if.master     bus
);
    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [31:0]      r_instr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_req;
    logic             w_valid;
    logic             w_latch;
    logic             w_cnt_inc;
    logic [1:0]       w_mode;
    logic [XLEN-1:0]  w_imm;
    logic             w_is_jal;
    logic [XLEN-1:0]  w_jal_imm;
    logic [XLEN-1:0]  w_redir_imm;

    jal_predecode #(.XLEN(XLEN)) u_predecode (
        .i_instr  (r_instr),
        .o_is_jal (w_is_jal),
        .o_imm    (w_jal_imm)
    );

    // Redirect targets are forced word-aligned.
    assign w_redir_imm = {redir_target_i[XLEN-1:2], 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        w_mode      = PC_STALL;
        w_imm       = '0;
        w_req       = 1'b0;
        w_valid     = 1'b0;
        w_latch     = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_req = ~stall_i;
                if (redir_valid_i) begin
                    w_mode = PC_JALR;
                    w_imm  = w_redir_imm;
                    // A request granted this cycle targets the stale PC;
                    // its response must be swallowed.
                    if (w_req && bus.imem_gnt_i) w_state_nxt = ST_DROP;
                end else if (w_req && bus.imem_gnt_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redir_valid_i) begin
                    w_mode      = PC_JALR;
                    w_imm       = w_redir_imm;
                    w_state_nxt = bus.imem_rvalid_i ? ST_REQ : ST_DROP;
                end else if (bus.imem_rvalid_i) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redir_valid_i) begin
                    w_mode      = PC_JALR;
                    w_imm       = w_redir_imm;
                    w_state_nxt = ST_REQ;
                end else begin
                    w_valid = 1'b1;
                    if (bus.instr_ready_i) begin
                        w_cnt_inc   = 1'b1;
                        w_state_nxt = ST_REQ;
                        if (w_is_jal) begin
                            w_mode = PC_BRANCH;
                            w_imm  = w_jal_imm;
                        end else begin
                            w_mode = PC_INCR;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (redir_valid_i) begin
                    w_mode = PC_JALR;
                    w_imm  = w_redir_imm;
                end
                if (bus.imem_rvalid_i) w_state_nxt = ST_REQ;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_instr <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) r_instr <= bus.imem_rdata_i;
            if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign pc_mode_o         = w_mode;
    assign pc_imm_o          = w_imm;
    assign fetch_cnt_o       = r_cnt;
    assign state_o           = r_state;
    assign bus.imem_req_o    = w_req;
    assign bus.imem_addr_o   = pc_i;
    assign bus.instr_valid_o = w_valid;
    assign bus.instr_o       = r_instr;
    assign bus.instr_pc_o    = pc_i;
endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
    import rv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [1:0]  pc_mode;
    logic [31:0] pc_imm;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic [31:0] fetch_cnt;
    fetch_state_t state;

    int n_vec;
    int n_err;

    fetch_ctrl_if #(.XLEN(32)) bus ();

    fetch_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_i           (pc),
        .pc_mode_o      (pc_mode),
        .pc_imm_o       (pc_imm),
        .stall_i        (stall),
        .redir_valid_i  (redir_valid),
        .redir_target_i (redir_target),
        .fetch_cnt_o    (fetch_cnt),
        .state_o        (state),
        .bus            (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model driven by the DUT's mode/imm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else begin
            case (pc_mode)
                PC_INCR:   pc <= pc + 32'd4;
                PC_BRANCH: pc <= pc + pc_imm;
                PC_JALR:   pc <= pc_imm;
                default:   pc <= pc;
            endcase
        end
    end

    typedef struct {
        logic        stall;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] target;
        logic [2:0]  e_state;
        logic        e_req;
        logic [31:0] e_addr;
        logic [1:0]  e_mode;
        logic [31:0] e_imm;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_cnt;
    } vec_t;

    localparam logic [2:0] I = 3'd0, R = 3'd1, W = 3'd2, H = 3'd3, D = 3'd4;
    localparam logic [1:0] MS = 2'b00, MI = 2'b01, MB = 2'b11, MJ = 2'b10;

    vec_t vecs[28];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall                = v.stall;
        bus.imem_gnt_i       = v.gnt;
        bus.imem_rvalid_i    = v.rvalid;
        bus.imem_rdata_i     = v.rdata;
        bus.instr_ready_i    = v.ready;
        redir_valid          = v.redir;
        redir_target         = v.target;
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        check("state",     idx, {29'd0, state},              {29'd0, v.e_state});
        check("imem_req",  idx, {31'd0, bus.imem_req_o},     {31'd0, v.e_req});
        check("imem_addr", idx, bus.imem_addr_o,             v.e_addr);
        check("pc_mode",   idx, {30'd0, pc_mode},            {30'd0, v.e_mode});
        check("pc_imm",    idx, pc_imm,                      v.e_imm);
        check("valid",     idx, {31'd0, bus.instr_valid_o},  {31'd0, v.e_valid});
        check("instr",     idx, bus.instr_o,                 v.e_instr);
        check("instr_pc",  idx, bus.instr_pc_o,              v.e_addr);
        check("fetch_cnt", idx, fetch_cnt,                   v.e_cnt);
    endtask

    // Entered 1 time unit after a rising edge; leaves 1 unit after the next one.
    task automatic apply(input int idx, input vec_t v);
        drive(v);
        #3;
        check_vec(idx, v);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic g, input logic rv,
                                input logic [31:0] rd, input logic rdy, input logic rdr,
                                input logic [31:0] tg, input logic [2:0] es,
                                input logic eq, input logic [31:0] ea, input logic [1:0] em,
                                input logic [31:0] ei, input logic ev,
                                input logic [31:0] ein, input logic [31:0] ec);
        vec_t v;
        v.stall = st; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
        v.redir = rdr; v.target = tg; v.e_state = es; v.e_req = eq; v.e_addr = ea;
        v.e_mode = em; v.e_imm = ei; v.e_valid = ev; v.e_instr = ein; v.e_cnt = ec;
        return v;
    endfunction

    initial begin
        vec_t v;
        n_vec = 0;
        n_err = 0;

        //               st g  rv rdata         rdy rdr target     st eq addr       mode imm        ev instr         cnt
        vecs[0]  = mk(0, 0, 0, 32'h0,        0, 1, 32'h100,  I, 0, 32'h0,   MS, 32'h0,   0, 32'h0,        32'd0);
        vecs[1]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,    R, 1, 32'h0,   MS, 32'h0,   0, 32'h0,        32'd0);
        vecs[2]  = mk(0, 0, 1, 32'h13,       0, 0, 32'h0,    W, 0, 32'h0,   MS, 32'h0,   0, 32'h0,        32'd0);
        vecs[3]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,    H, 0, 32'h0,   MI, 32'h0,   1, 32'h13,       32'd0);
        vecs[4]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,    R, 1, 32'h4,   MS, 32'h0,   0, 32'h13,       32'd1);
        vecs[5]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,    R, 1, 32'h4,   MS, 32'h0,   0, 32'h13,       32'd1);
        vecs[6]  = mk(0, 0, 1, 32'h00100093, 0, 0, 32'h0,    W, 0, 32'h4,   MS, 32'h0,   0, 32'h13,       32'd1);
        vecs[7]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,    H, 0, 32'h4,   MS, 32'h0,   1, 32'h00100093, 32'd1);
        vecs[8]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,    H, 0, 32'h4,   MI, 32'h0,   1, 32'h00100093, 32'd1);
        vecs[9]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,    R, 1, 32'h8,   MS, 32'h0,   0, 32'h00100093, 32'd2);
        vecs[10] = mk(0, 0, 1, 32'h0100006F, 0, 0, 32'h0,    W, 0, 32'h8,   MS, 32'h0,   0, 32'h00100093, 32'd2);
        vecs[11] = mk(1, 0, 0, 32'h0,        1, 0, 32'h0,    H, 0, 32'h8,   MB, 32'h10,  1, 32'h0100006F, 32'd2);
        vecs[12] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,    R, 1, 32'h18,  MS, 32'h0,   0, 32'h0100006F, 32'd3);
        vecs[13] = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,    R, 0, 32'h18,  MS, 32'h0,   0, 32'h0100006F, 32'd3);
        vecs[14] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,    R, 1, 32'h18,  MS, 32'h0,   0, 32'h0100006F, 32'd3);
        vecs[15] = mk(0, 0, 0, 32'h0,        0, 1, 32'h203,  W, 0, 32'h18,  MJ, 32'h200, 0, 32'h0100006F, 32'd3);
        vecs[16] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,    D, 0, 32'h200, MS, 32'h0,   0, 32'h0100006F, 32'd3);
        vecs[17] = mk(0, 0, 1, 32'hDEADBEEF, 1, 0, 32'h0,    D, 0, 32'h200, MS, 32'h0,   0, 32'h0100006F, 32'd3);
        vecs[18] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,    R, 1, 32'h200, MS, 32'h0,   0, 32'h0100006F, 32'd3);
        vecs[19] = mk(0, 0, 1, 32'h13,       0, 0, 32'h0,    W, 0, 32'h200, MS, 32'h0,   0, 32'h0100006F, 32'd3);
        vecs[20] = mk(0, 0, 0, 32'h0,        1, 1, 32'h300,  H, 0, 32'h200, MJ, 32'h300, 0, 32'h13,       32'd3);
        vecs[21] = mk(0, 1, 0, 32'h0,        0, 1, 32'h404,  R, 1, 32'h300, MJ, 32'h404, 0, 32'h13,       32'd3);
        vecs[22] = mk(0, 0, 0, 32'h0,        0, 1, 32'h500,  D, 0, 32'h404, MJ, 32'h500, 0, 32'h13,       32'd3);
        vecs[23] = mk(0, 0, 1, 32'h12345678, 0, 0, 32'h0,    D, 0, 32'h500, MS, 32'h0,   0, 32'h13,       32'd3);
        vecs[24] = mk(0, 0, 0, 32'h0,        0, 1, 32'h600,  R, 1, 32'h500, MJ, 32'h600, 0, 32'h13,       32'd3);
        vecs[25] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,    R, 1, 32'h600, MS, 32'h0,   0, 32'h13,       32'd3);
        vecs[26] = mk(0, 0, 1, 32'hAAAAAAAA, 1, 1, 32'h701,  W, 0, 32'h600, MJ, 32'h700, 0, 32'h13,       32'd3);
        vecs[27] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,    R, 1, 32'h700, MS, 32'h0,   0, 32'h13,       32'd3);

        // Reset phase
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, I, 0, 32'h0, MS, 32'h0, 0, 32'h0, 32'd0));
        repeat (2) @(posedge clk);
        #1;
        check_vec(100, mk(0, 0, 0, 32'h0, 0, 0, 32'h0, I, 0, 32'h0, MS, 32'h0, 0, 32'h0, 32'd0));
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) apply(i, vecs[i]);

        // Stall held five cycles in REQ: no request, PC frozen.
        for (int i = 0; i < 5; i++)
            apply(200 + i, mk(1, 0, 0, 32'h0, 0, 0, 32'h0, R, 0, 32'h700, MS, 32'h0, 0, 32'h13, 32'd3));
        // Release: request goes out in the same cycle and is granted.
        apply(205, mk(0, 1, 0, 32'h0, 0, 0, 32'h0, R, 1, 32'h700, MS, 32'h0, 0, 32'h13, 32'd3));
        // Backward JAL (-8) fetched.
        apply(206, mk(0, 0, 1, 32'hFF9FF06F, 0, 0, 32'h0, W, 0, 32'h700, MS, 32'h0, 0, 32'h13, 32'd3));

        // Counter wrap: preload all-ones, then one handoff.
        force dut.r_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_cnt;
        apply(207, mk(0, 0, 0, 32'h0, 1, 0, 32'h0, H, 0, 32'h700, MB, 32'hFFFF_FFF8, 1, 32'hFF9FF06F, 32'hFFFF_FFFF));
        apply(208, mk(0, 1, 0, 32'h0, 0, 0, 32'h0, R, 1, 32'h6F8, MS, 32'h0, 0, 32'hFF9FF06F, 32'd0));

        // Now in WAIT: asynchronous reset mid-transaction.
        v = mk(0, 0, 0, 32'h0, 0, 0, 32'h0, I, 0, 32'h0, MS, 32'h0, 0, 32'h0, 32'd0);
        check("pre_rst_state", 209, {29'd0, state}, {29'd0, W});
        drive(v);
        rst_n = 1'b0;
        #1;
        check_vec(210, v);
        // A response arriving while in reset / IDLE must be ignored.
        drive(mk(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0, I, 0, 32'h0, MS, 32'h0, 0, 32'h0, 32'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(211, mk(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0, I, 0, 32'h0, MS, 32'h0, 0, 32'h0, 32'd0));
        apply(212, mk(0, 0, 0, 32'h0, 0, 0, 32'h0, R, 1, 32'h0, MS, 32'h0, 0, 32'h0, 32'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
